// File: rtl/traffic_phase_sequencer.sv
// Intersection phase sequencer driving an external countdown timer plus NS/EW/pedestrian lamps.
// Optional flashing don't-walk clearance phase is enabled by defining PED_FLASH_EN.
module traffic_phase_sequencer #(
    parameter logic [3:0] T_GREEN  = 4'd6,
    parameter logic [3:0] T_YELLOW = 4'd2,
    parameter logic [3:0] T_RED    = 4'd1,
    parameter logic [3:0] T_WALK   = 4'd5,
    parameter logic [3:0] T_CLR    = 4'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped,
    input  logic [3:0] timer_out,
    output logic       timer_en,
    output logic       timer_load,
    output logic [3:0] timer_init,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic [1:0] light_ped
);

    typedef enum logic [2:0] {
        S_RED,
        S_NS_G,
        S_NS_Y,
        S_EW_G,
        S_EW_Y,
        S_WALK
`ifdef PED_FLASH_EN
        , S_CLR
`endif
    } state_e;

    if (T_GREEN == 4'd0 || T_YELLOW == 4'd0 || T_RED == 4'd0 ||
        T_WALK == 4'd0 || T_CLR == 4'd0) begin : g_bad_param
        $error("traffic_phase_sequencer: phase durations must be 1..15");
    end

    state_e     state_q, state_d;
    logic       entry_q, entry_d;
    logic       last_ns_q, last_ns_d;   // 1: NS served last, 0: EW served last
    logic       ped_pend_q, ped_pend_d;
    logic       expired;
    logic       ped_accept;
    logic [3:0] dur;
`ifdef PED_FLASH_EN
    logic       flash_q, flash_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RED;
            entry_q    <= 1'b1;
            last_ns_q  <= 1'b0;
            ped_pend_q <= 1'b0;
`ifdef PED_FLASH_EN
            flash_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            last_ns_q  <= last_ns_d;
            ped_pend_q <= ped_pend_d;
`ifdef PED_FLASH_EN
            flash_q    <= flash_d;
`endif
        end
    end

    // Timer count is stale on the entry cycle, so expiry is masked there.
    assign expired = !entry_q && (timer_out == 4'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_NS_G: if (expired && (car_ew || ped_pend_q)) state_d = S_NS_Y;
            S_EW_G: if (expired && (car_ns || ped_pend_q)) state_d = S_EW_Y;
            S_NS_Y: if (expired) state_d = S_RED;
            S_EW_Y: if (expired) state_d = S_RED;
            S_RED: begin
                if (expired) begin
                    if (ped_pend_q)     state_d = S_WALK;
                    else if (last_ns_q) state_d = S_EW_G;
                    else                state_d = S_NS_G;
                end
            end
`ifdef PED_FLASH_EN
            S_WALK: if (expired) state_d = S_CLR;
            S_CLR:  if (expired) state_d = S_RED;
`else
            S_WALK: if (expired) state_d = S_RED;
`endif
            default: state_d = S_RED;
        endcase

        entry_d = (state_d != state_q);

        last_ns_d = last_ns_q;
        if (state_d == S_NS_G) last_ns_d = 1'b1;
        if (state_d == S_EW_G) last_ns_d = 1'b0;

`ifdef PED_FLASH_EN
        ped_accept = (state_q != S_WALK) && (state_q != S_CLR);
        flash_d    = (state_q == S_CLR) ? ~flash_q : 1'b0;
`else
        ped_accept = (state_q != S_WALK);
`endif
        ped_pend_d = ped_pend_q;
        if (ped && ped_accept)             ped_pend_d = 1'b1;
        if (state_q == S_WALK && entry_q)  ped_pend_d = 1'b0;
    end

    always_comb begin
        case (state_q)
            S_NS_G, S_EW_G: dur = T_GREEN;
            S_NS_Y, S_EW_Y: dur = T_YELLOW;
            S_WALK:         dur = T_WALK;
`ifdef PED_FLASH_EN
            S_CLR:          dur = T_CLR;
`endif
            default:        dur = T_RED;
        endcase

        timer_en   = 1'b1;
        timer_load = entry_q;
        timer_init = entry_q ? dur : '0;

        light_ns  = 3'b100;
        light_ew  = 3'b100;
        light_ped = 2'b01;
        case (state_q)
            S_NS_G: light_ns  = 3'b001;
            S_NS_Y: light_ns  = 3'b010;
            S_EW_G: light_ew  = 3'b001;
            S_EW_Y: light_ew  = 3'b010;
            S_WALK: light_ped = 2'b10;
`ifdef PED_FLASH_EN
            S_CLR:  light_ped = flash_q ? 2'b00 : 2'b01;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed scoreboard bench for traffic_phase_sequencer with a reference countdown timer.
// Honours PED_FLASH_EN the same way as the design.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst, car_ns, car_ew, ped;
    logic [3:0] timer_out = '0;
    logic       timer_en, timer_load;
    logic [3:0] timer_init;
    logic [2:0] light_ns, light_ew;
    logic [1:0] light_ped;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [2:0] ns;
        logic [2:0] ew;
        logic [1:0] pd;
        logic       ld;
        logic [3:0] init;
    } exp_t;

    exp_t sb[$];
    int   seq[$];

    traffic_phase_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .car_ns     (car_ns),
        .car_ew     (car_ew),
        .ped        (ped),
        .timer_out  (timer_out),
        .timer_en   (timer_en),
        .timer_load (timer_load),
        .timer_init (timer_init),
        .light_ns   (light_ns),
        .light_ew   (light_ew),
        .light_ped  (light_ped)
    );

    always #5 clk = ~clk;

    // Reference timer: load wins, else decrement while enabled, hold at zero.
    always @(posedge clk) begin
        if (timer_load)                        timer_out <= timer_init;
        else if (timer_en && timer_out != 4'd0) timer_out <= timer_out - 4'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                        input logic [1:0] pd, input logic ld, input logic [3:0] init);
        exp_t e;
        e.tag = tag; e.ns = ns; e.ew = ew; e.pd = pd; e.ld = ld; e.init = init;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        e = sb.pop_front();
        n_assert++;
        assert ({light_ns, light_ew, light_ped, timer_en, timer_load, timer_init} ===
                {e.ns, e.ew, e.pd, 1'b1, e.ld, e.init}) else begin
            n_fail++;
            $error("FAIL %s: observed ns=%b ew=%b ped=%b en=%b load=%b init=%0d expected ns=%b ew=%b ped=%b en=1 load=%b init=%0d",
                   e.tag, light_ns, light_ew, light_ped, timer_en, timer_load, timer_init,
                   e.ns, e.ew, e.pd, e.ld, e.init);
        end
    endtask

    // Checks the current cycle against the queue head, stepping between entries.
    task automatic run_sb();
        while (sb.size() > 0) begin
            check_pop();
            if (sb.size() > 0) step();
        end
    endtask

    task automatic wait_lamp(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                             input logic [1:0] pd, input int budget);
        int i = 0;
        while (!(light_ns === ns && light_ew === ew && light_ped === pd) && i < budget) begin
            step();
            i++;
        end
        check(tag, int'(i < budget), 1);
    endtask

    task automatic push_red(input string tag);
        push(tag, 3'b100, 3'b100, 2'b01, 1'b1, 4'd1);
        for (int i = 0; i < 2; i++) push(tag, 3'b100, 3'b100, 2'b01, 1'b0, 4'd0);
    endtask

    task automatic push_ped_walk(input string tag);
        push(tag, 3'b100, 3'b100, 2'b10, 1'b1, 4'd5);
        for (int i = 0; i < 6; i++) push(tag, 3'b100, 3'b100, 2'b10, 1'b0, 4'd0);
    endtask

    initial begin
        int code, last_code;
        bit ok;

        rst = 1'b1; car_ns = 1'b0; car_ew = 1'b0; ped = 1'b0;

        // Reset and release
        step();
        push("during_rst", 3'b100, 3'b100, 2'b01, 1'b1, 4'd1);
        check_pop();
        step();
        rst = 1'b0;
        push("rel_c0", 3'b100, 3'b100, 2'b01, 1'b1, 4'd1);
        push("rel_c1", 3'b100, 3'b100, 2'b01, 1'b0, 4'd0);
        push("rel_c2", 3'b100, 3'b100, 2'b01, 1'b0, 4'd0);
        push("rel_c3", 3'b001, 3'b100, 2'b01, 1'b1, 4'd6);
        run_sb();

        // NS green holds without demand, no reload
        step();
        for (int i = 0; i < 25; i++) push("ns_hold", 3'b001, 3'b100, 2'b01, 1'b0, 4'd0);
        run_sb();

        // Conflicting car request exits hold on the next cycle
        car_ew = 1'b1;
        step();
        car_ew = 1'b0;
        push("ns_yel", 3'b010, 3'b100, 2'b01, 1'b1, 4'd2);
        for (int i = 0; i < 3; i++) push("ns_yel", 3'b010, 3'b100, 2'b01, 1'b0, 4'd0);
        push_red("red_to_ew");
        push("ew_grn", 3'b100, 3'b001, 2'b01, 1'b1, 4'd6);
        run_sb();

        // Return to NS green, then a single-cycle pedestrian pulse
        car_ns = 1'b1;
        wait_lamp("ew_to_ns", 3'b001, 3'b100, 2'b01, 30);
        car_ns = 1'b0;
        for (int i = 0; i < 10; i++) step();
        ped = 1'b1;
        step();
        ped = 1'b0;
        wait_lamp("ped_yel_wait", 3'b010, 3'b100, 2'b01, 4);
        push("ped_yel", 3'b010, 3'b100, 2'b01, 1'b1, 4'd2);
        for (int i = 0; i < 3; i++) push("ped_yel", 3'b010, 3'b100, 2'b01, 1'b0, 4'd0);
        push_red("ped_red1");
        push_ped_walk("ped_walk");
`ifdef PED_FLASH_EN
        push("ped_clr", 3'b100, 3'b100, 2'b01, 1'b1, 4'd3);
        push("ped_clr", 3'b100, 3'b100, 2'b00, 1'b0, 4'd0);
        push("ped_clr", 3'b100, 3'b100, 2'b01, 1'b0, 4'd0);
        push("ped_clr", 3'b100, 3'b100, 2'b00, 1'b0, 4'd0);
        push("ped_clr", 3'b100, 3'b100, 2'b01, 1'b0, 4'd0);
`endif
        push_red("ped_red2");
        push("ped_ew_grn", 3'b100, 3'b001, 2'b01, 1'b1, 4'd6);
        run_sb();

        // Reset in the middle of a walk phase
        ped = 1'b1;
        step();
        ped = 1'b0;
        wait_lamp("walk_wait", 3'b100, 3'b100, 2'b10, 30);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_red("mid_walk_rst");
        push("rst_ns_grn", 3'b001, 3'b100, 2'b01, 1'b1, 4'd6);
        run_sb();

        // Simultaneous demand: cars held, pedestrian requested during each green
        car_ns = 1'b1;
        car_ew = 1'b1;
        last_code = -2;
        for (int i = 0; i < 300 && seq.size() < 9; i++) begin
            ok = !((light_ns != 3'b100 && light_ew != 3'b100) ||
                   (light_ped == 2'b10 && (light_ns != 3'b100 || light_ew != 3'b100)));
            check("no_conflict", int'(ok), 1);
            if (light_ns == 3'b001)       code = 1;
            else if (light_ew == 3'b001)  code = 2;
            else if (light_ped == 2'b10)  code = 3;
            else if (light_ns == 3'b100 && light_ew == 3'b100) code = 0;
            else                          code = -1;
            if (code >= 0 && code != last_code) begin
                seq.push_back(code);
                last_code = code;
            end
            ped = (light_ns == 3'b001) || (light_ew == 3'b001);
            step();
        end
        ped = 1'b0;
        car_ns = 1'b0;
        car_ew = 1'b0;
        check("rot_len", seq.size(), 9);
        begin
            int exp_seq[9] = '{1, 0, 3, 0, 2, 0, 3, 0, 1};
            for (int i = 0; i < 9 && i < seq.size(); i++)
                check($sformatf("rot_%0d", i), seq[i], exp_seq[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
